// File: rtl/tx_arb_pkg.sv
// Shared definitions for the transmitter word arbiter: state encoding, clog2 helper, default width.
package tx_arb_pkg;

  localparam int unsigned DEF_DATA_W = 382;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_TX_RST       = 3'd1,
    S_START        = 3'd2,
    S_WAIT         = 3'd3,
    S_ACK          = 3'd4,
    S_TX_RST_ABORT = 3'd5
  } state_t;

  // Ceiling log2, never below 1 so single-bit indices stay legal.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/tx_word_arbiter_rr_pick.sv
// Round-robin pick: first set request searching upward from ptr+1, wrapping.
module rr_pick
  import tx_arb_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx
);

  logic         found;
  logic [W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = W'((32'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/tx_word_arbiter.sv
// Shares one word transmitter among N_REQ requesters: round-robin grant, reset/start/done sequencing.
// Optional tx_done watchdog with abort path is enabled by defining TX_ARB_WATCHDOG_EN.
module tx_word_arbiter
  import tx_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = 3,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 600000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  output logic [clog2(N_REQ)-1:0]   grant_id,
  output logic                      busy,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_start,
  output logic                      tx_reset,
  input  logic                      tx_done,
  output logic                      tx_err
);

  localparam int unsigned ID_W = clog2(N_REQ);

  state_t              state;
  logic [ID_W-1:0]     ptr;
  logic [N_REQ-1:0]    pick_grant;
  logic [ID_W-1:0]     pick_idx;
  logic [DATA_W-1:0]   pick_word;

  rr_pick #(.N(N_REQ), .W(ID_W)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_word = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_grant[i]) pick_word = req_data[i*DATA_W +: DATA_W];
    end
  end

`ifdef TX_ARB_WATCHDOG_EN
  logic [31:0] wd_cnt;
  assign tx_reset = reset | (state == S_TX_RST) | (state == S_TX_RST_ABORT);
`else
  logic unused_cfg;
  assign unused_cfg = ^32'(TIMEOUT_CYC);
  assign tx_reset   = reset | (state == S_TX_RST);
  assign tx_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ptr      <= ID_W'(N_REQ - 1);
      grant_id <= '0;
      ack      <= '0;
      busy     <= 1'b0;
      tx_data  <= '0;
      tx_start <= 1'b0;
`ifdef TX_ARB_WATCHDOG_EN
      wd_cnt   <= '0;
      tx_err   <= 1'b0;
`endif
    end else begin
      ack <= '0;
`ifdef TX_ARB_WATCHDOG_EN
      tx_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (|req) begin
            grant_id <= pick_idx;
            ptr      <= pick_idx;
            tx_data  <= pick_word;
            busy     <= 1'b1;
            state    <= S_TX_RST;
          end
        end
        S_TX_RST: begin
          tx_start <= 1'b1;
          state    <= S_START;
        end
        S_START: begin
`ifdef TX_ARB_WATCHDOG_EN
          wd_cnt <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done) begin
            tx_start      <= 1'b0;
            ack[grant_id] <= 1'b1;
            state         <= S_ACK;
          end
`ifdef TX_ARB_WATCHDOG_EN
          // Abort without ack; ptr keeps the aborted winner so the next one gets a turn.
          else if (wd_cnt == 32'(TIMEOUT_CYC - 1)) begin
            tx_start <= 1'b0;
            tx_err   <= 1'b1;
            state    <= S_TX_RST_ABORT;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
`endif
        end
        S_ACK: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
`ifdef TX_ARB_WATCHDOG_EN
        S_TX_RST_ABORT: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
`endif
        default: begin
          busy     <= 1'b0;
          tx_start <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_word_arbiter.sv
// Bench for tx_word_arbiter with a sticky-done transmitter model and an ack scoreboard.
module tb_tx_word_arbiter;
  import tx_arb_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 382;
  localparam int unsigned TO = 50;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      ack;
  logic [1:0]        grant_id;
  logic              busy;
  logic [DW-1:0]     tx_data;
  logic              tx_start;
  logic              tx_reset;
  logic              tx_done;
  logic              tx_err;

  always #5 clk = ~clk;

  tx_word_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_reset (tx_reset),
    .tx_done  (tx_done),
    .tx_err   (tx_err)
  );

  // Transmitter model: sticky done 20 cycles after start, cleared by tx_reset.
  logic done_m;
  int   mcnt;
  logic no_done = 1'b0;
  always @(posedge clk) begin
    if (tx_reset) begin
      done_m <= 1'b0;
      mcnt   <= 0;
    end else if (tx_start && !done_m) begin
      mcnt <= mcnt + 1;
      if (mcnt == 19 && !no_done) done_m <= 1'b1;
    end
  end
  assign tx_done = done_m;

  typedef struct { int id; logic [DW-1:0] data; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [N-1:0] exp_ack;
  int total = 0;
  int bad = 0;
  int rst_pulses = 0;

  // Ack monitor: every ack must match the head of the scoreboard.
  always @(negedge clk) begin
    if (tx_reset === 1'b1 && reset === 1'b0) rst_pulses++;
    if (reset === 1'b0 && ack !== 3'b000) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack: ack=%b, none expected", ack);
      end else begin
        mon_e   = exp_q.pop_front();
        exp_ack = 3'b001 << mon_e.id;
        if (ack !== exp_ack || tx_data !== mon_e.data) begin
          bad++;
          $display("FAIL ack_word: ack=%b tx_data=%h expected ack=%b tx_data=%h",
                   ack, tx_data, exp_ack, mon_e.data);
        end
      end
    end
  end

  function automatic logic [DW-1:0] mk_word(input logic [7:0] seed);
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < 47; k++) w[8*k +: 8] = seed + 8'(k);
    w[DW-1 -: 6] = 6'(seed);
    return w;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input string name);
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && req == '0 && busy === 1'b0) && k < budget) begin
      @(negedge clk);
      k++;
      for (int i = 0; i < N; i++) if (ack[i] === 1'b1) req[i] = 1'b0;
    end
    total++;
    if (k >= budget) begin
      bad++;
      $display("FAIL %s_timeout: still busy=%b req=%b pending=%0d after %0d cycles, required idle",
               name, busy, req, exp_q.size(), k);
    end
  endtask

  task automatic wait_start(input string name);
    int k;
    k = 0;
    while (tx_start !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    total++;
    if (tx_start !== 1'b1) begin
      bad++;
      $display("FAIL %s_start: tx_start=%b, required 1 within 20 cycles", name, tx_start);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total += 7;
    if (ack !== 3'b000)      begin bad++; $display("FAIL rst_ack: got %b need 000", ack); end
    if (grant_id !== 2'd0)   begin bad++; $display("FAIL rst_grant: got %0d need 0", grant_id); end
    if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %b need 0", busy); end
    if (tx_data !== '0)      begin bad++; $display("FAIL rst_data: got %h need 0", tx_data); end
    if (tx_start !== 1'b0)   begin bad++; $display("FAIL rst_start: got %b need 0", tx_start); end
    if (tx_err !== 1'b0)     begin bad++; $display("FAIL rst_err: got %b need 0", tx_err); end
    if (tx_reset !== 1'b1)   begin bad++; $display("FAIL rst_txreset: got %b need 1", tx_reset); end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (tx_reset !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL post_rst: tx_reset=%b busy=%b need 0 0", tx_reset, busy);
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] w;
    int k;
    w = mk_word(8'h41);
    req_data[1*DW +: DW] = w;
    req = 3'b010;
    exp_q.push_back('{1, w});
    @(negedge clk);
    total += 3;
    if (tx_reset !== 1'b1 || tx_start !== 1'b0) begin
      bad++; $display("FAIL single_c1: tx_reset=%b tx_start=%b need 1 0", tx_reset, tx_start);
    end
    if (grant_id !== 2'd1 || busy !== 1'b1) begin
      bad++; $display("FAIL single_grant: grant_id=%0d busy=%b need 1 1", grant_id, busy);
    end
    if (tx_data !== w) begin bad++; $display("FAIL single_data: got %h need %h", tx_data, w); end
    @(negedge clk);
    total++;
    if (tx_reset !== 1'b0 || tx_start !== 1'b1) begin
      bad++; $display("FAIL single_c2: tx_reset=%b tx_start=%b need 0 1", tx_reset, tx_start);
    end
    req_data[1*DW +: DW] = ~w;
    k = 0;
    while (ack === 3'b000 && k < 100) begin @(negedge clk); k++; end
    req = '0;
    total++;
    if (k != 21) begin bad++; $display("FAIL single_latency: ack %0d cycles after start, need 21", k); end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || ack !== 3'b000) begin
      bad++; $display("FAIL single_end: busy=%b ack=%b need 0 000", busy, ack);
    end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] w [N];
    int acks, k;
    do_reset();
    @(negedge clk);
    rst_pulses = 0;
    for (int i = 0; i < N; i++) begin
      w[i] = mk_word(8'(8'h10 * (i + 1)));
      req_data[i*DW +: DW] = w[i];
    end
    exp_q.push_back('{0, w[0]});
    exp_q.push_back('{1, w[1]});
    exp_q.push_back('{2, w[2]});
    exp_q.push_back('{0, w[0]});
    req  = 3'b111;
    acks = 0;
    k    = 0;
    while (acks < 4 && k < 300) begin
      @(negedge clk);
      k++;
      if (ack !== 3'b000) begin
        acks++;
        if (acks == 4) req = '0;
      end
    end
    req = '0;
    repeat (3) @(negedge clk);
    total += 2;
    if (acks != 4) begin bad++; $display("FAIL rr_acks: got %0d acks need 4", acks); end
    if (rst_pulses != 4) begin bad++; $display("FAIL rr_txreset: got %0d pulses need 4", rst_pulses); end
  endtask

  task automatic test_drop();
    logic [DW-1:0] w;
    int extra;
    do_reset();
    w = mk_word(8'h60);
    req_data[2*DW +: DW] = w;
    req = 3'b100;
    exp_q.push_back('{2, w});
    wait_start("drop");
    repeat (5) @(negedge clk);
    req = '0;
    run_until_done(100, "drop");
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx_start !== 1'b0) extra++;
    end
    total++;
    if (extra != 0) begin bad++; $display("FAIL drop_regrant: %0d busy cycles after drop, need 0", extra); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w0, w1;
    do_reset();
    w1 = mk_word(8'h70);
    req_data[1*DW +: DW] = w1;
    req = 3'b010;
    wait_start("rstmid");
    repeat (5) @(negedge clk);
    reset = 1'b1;
    w0 = mk_word(8'h80);
    req_data[0*DW +: DW] = w0;
    req = 3'b011;
    @(negedge clk);
    total += 3;
    if (busy !== 1'b0 || tx_start !== 1'b0 || ack !== 3'b000 || tx_err !== 1'b0) begin
      bad++; $display("FAIL rstmid_ctl: busy=%b tx_start=%b ack=%b tx_err=%b need 0", busy, tx_start, ack, tx_err);
    end
    if (tx_data !== '0 || grant_id !== 2'd0) begin
      bad++; $display("FAIL rstmid_data: grant_id=%0d tx_data=%h need 0", grant_id, tx_data);
    end
    if (tx_reset !== 1'b1) begin bad++; $display("FAIL rstmid_txreset: got %b need 1", tx_reset); end
    reset = 1'b0;
    exp_q.push_back('{0, w0});
    exp_q.push_back('{1, w1});
    run_until_done(200, "rstmid");
  endtask

`ifdef TX_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    logic [DW-1:0] w0, w1;
    int k;
    do_reset();
    w0 = mk_word(8'h90);
    w1 = mk_word(8'hA0);
    req_data[0*DW +: DW] = w0;
    req_data[1*DW +: DW] = w1;
    no_done = 1'b1;
    req = 3'b011;
    wait_start("wd");
    k = 0;
    while (tx_err !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    total += 2;
    if (k != 51) begin bad++; $display("FAIL wd_latency: tx_err %0d cycles after start, need 51", k); end
    if (tx_reset !== 1'b1 || ack !== 3'b000) begin
      bad++; $display("FAIL wd_abort: tx_reset=%b ack=%b need 1 000", tx_reset, ack);
    end
    no_done = 1'b0;
    exp_q.push_back('{1, w1});
    exp_q.push_back('{0, w0});
    @(negedge clk);
    @(negedge clk);
    total++;
    if (grant_id !== 2'd1 || tx_err !== 1'b0) begin
      bad++; $display("FAIL wd_next: grant_id=%0d tx_err=%b need 1 0", grant_id, tx_err);
    end
    run_until_done(200, "wd");
  endtask
`else
  task automatic test_no_watchdog();
    int busy_low, err_high;
    do_reset();
    no_done = 1'b1;
    req_data[0*DW +: DW] = mk_word(8'hB0);
    req = 3'b001;
    repeat (2) @(negedge clk);
    busy_low = 0;
    err_high = 0;
    repeat (10000) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_low++;
      if (tx_err !== 1'b0) err_high++;
    end
    total += 2;
    if (busy_low != 0) begin bad++; $display("FAIL nowd_busy: %0d cycles busy low, need 0", busy_low); end
    if (err_high != 0) begin bad++; $display("FAIL nowd_err: %0d cycles tx_err high, need 0", err_high); end
    do_reset();
    no_done = 1'b0;
  endtask
`endif

  initial begin
    reset    = 1'b1;
    req      = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_drop();
    test_reset_mid();
`ifdef TX_ARB_WATCHDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL leftover: %0d acks outstanding, need 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
